// File: rtl/dbg_cmd_engine.sv
// Debug command engine: loads instruction memory, runs or single-steps the CPU
// and streams register, memory and pipeline-latch dumps. Optional macro: DBG_BREAKPOINT_EN.
module dbg_cmd_engine #(
  parameter int                 NB_WORD     = 32,
  parameter int                 N_REGS      = 32,
  parameter int                 N_MEM_WORDS = 32,
  parameter int                 NB_LATCH    = 376,
  parameter logic [NB_WORD-1:0] HALT_WORD   = 32'h0000003F
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  input  logic [NB_WORD-1:0]  i_reg_data,
  input  logic [NB_WORD-1:0]  i_mem_data,
  input  logic [NB_LATCH-1:0] i_latch,
  input  logic [NB_WORD-1:0]  i_pc,
  input  logic                i_halt,
  output logic [NB_WORD-1:0]  o_dbg_addr,
  output logic [NB_WORD-1:0]  o_inst,
  output logic                o_w_mem,
  output logic                o_enable,
  output logic                o_reset_mips,
  output logic                o_busy
);

  localparam int CW           = 16;
  localparam int NB_BYTES     = NB_WORD / 8;
  localparam int NB_LAT_BYTES = NB_LATCH / 8;

  localparam logic [7:0] CMD_RUN    = 8'h03;
  localparam logic [7:0] CMD_LOAD   = 8'h04;
  localparam logic [7:0] CMD_STEP   = 8'h05;
  localparam logic [7:0] CMD_RST    = 8'h0C;
  localparam logic [7:0] CMD_BP_SET = 8'h10;
  localparam logic [7:0] CMD_BP_CLR = 8'h11;
  localparam logic [7:0] BYTE_ACK   = 8'hAC;
  localparam logic [7:0] BYTE_NAK   = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMD      = 4'd1,
    ST_LOAD     = 4'd2,
    ST_WRITE    = 4'd3,
    ST_RUN      = 4'd4,
    ST_STEP     = 4'd5,
    ST_DUMP_REG = 4'd6,
    ST_DUMP_MEM = 4'd7,
    ST_DUMP_LAT = 4'd8,
    ST_FINISH   = 4'd9,
    ST_RST      = 4'd10,
    ST_ACK      = 4'd11,
    ST_NAK      = 4'd12,
    ST_BP_LOAD  = 4'd13
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [7:0]         cmd_r;
  logic [NB_WORD-1:0] shift_r;
  logic [CW-1:0]      byte_cnt_r;
  logic [CW-1:0]      word_cnt_r;
  logic [NB_WORD-1:0] load_addr_r;
  logic               from_run_r;

  logic               rx_hs_s;
  logic               tx_hs_s;
  logic               byte_last_s;
  logic               word_last_s;
  logic               lat_last_s;
  logic               is_halt_s;
  logic               bp_hit_s;
  logic [NB_WORD-1:0] shift_next_s;

  // Byte idx of a word, counted from the most significant byte.
  function automatic logic [7:0] word_byte(input logic [NB_WORD-1:0] word, input logic [CW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NB_BYTES; i++) begin
      b = (idx == CW'(i)) ? word[NB_WORD-1-8*i -: 8] : b;
    end
    return b;
  endfunction

  function automatic logic [7:0] latch_byte(input logic [NB_LATCH-1:0] lat, input logic [CW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NB_LAT_BYTES; i++) begin
      b = (idx == CW'(i)) ? lat[NB_LATCH-1-8*i -: 8] : b;
    end
    return b;
  endfunction

`ifdef DBG_BREAKPOINT_EN
  logic [NB_WORD-1:0] bp_addr_r;
  logic               bp_valid_r;

  assign bp_hit_s = bp_valid_r && (i_pc == bp_addr_r);
`else
  logic pc_unused_s;

  assign pc_unused_s = ^i_pc;
  assign bp_hit_s    = 1'b0;
`endif

  assign rx_hs_s      = i_rx_valid && o_rx_ready;
  assign tx_hs_s      = o_tx_valid && i_tx_ready;
  assign byte_last_s  = (byte_cnt_r == CW'(NB_BYTES - 1));
  assign lat_last_s   = (byte_cnt_r == CW'(NB_LAT_BYTES - 1));
  assign word_last_s  = (state_r == ST_DUMP_REG) ? (word_cnt_r == CW'(N_REGS - 1))
                                                 : (word_cnt_r == CW'(N_MEM_WORDS - 1));
  assign is_halt_s    = (shift_r == HALT_WORD);
  assign shift_next_s = {shift_r[NB_WORD-9:0], i_rx_data};

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_hs_s) state_s = ST_CMD;
        else         state_s = ST_IDLE;
      end
      ST_CMD: begin
        case (cmd_r)
          CMD_LOAD:   state_s = ST_LOAD;
          CMD_RUN:    state_s = ST_RUN;
          CMD_STEP:   state_s = ST_STEP;
          CMD_RST:    state_s = ST_RST;
`ifdef DBG_BREAKPOINT_EN
          CMD_BP_SET: state_s = ST_BP_LOAD;
          CMD_BP_CLR: state_s = ST_ACK;
`endif
          default:    state_s = ST_NAK;
        endcase
      end
      ST_LOAD: begin
        if (rx_hs_s && byte_last_s) state_s = ST_WRITE;
        else                        state_s = ST_LOAD;
      end
      ST_WRITE: begin
        if (is_halt_s) state_s = ST_IDLE;
        else           state_s = ST_LOAD;
      end
      ST_RUN: begin
        if (i_halt || bp_hit_s) state_s = ST_DUMP_REG;
        else                    state_s = ST_RUN;
      end
      ST_STEP: state_s = ST_DUMP_REG;
      ST_DUMP_REG: begin
        if (tx_hs_s && byte_last_s && word_last_s) state_s = ST_DUMP_MEM;
        else                                       state_s = ST_DUMP_REG;
      end
      ST_DUMP_MEM: begin
        if (tx_hs_s && byte_last_s && word_last_s) state_s = ST_DUMP_LAT;
        else                                       state_s = ST_DUMP_MEM;
      end
      ST_DUMP_LAT: begin
        if (tx_hs_s && lat_last_s) state_s = ST_FINISH;
        else                       state_s = ST_DUMP_LAT;
      end
      ST_FINISH: begin
        if (from_run_r) state_s = ST_RST;
        else            state_s = ST_IDLE;
      end
      ST_RST: state_s = ST_IDLE;
      ST_ACK, ST_NAK: begin
        if (tx_hs_s) state_s = ST_IDLE;
        else         state_s = state_r;
      end
      ST_BP_LOAD: begin
`ifdef DBG_BREAKPOINT_EN
        if (rx_hs_s && byte_last_s) state_s = ST_ACK;
        else                        state_s = ST_BP_LOAD;
`else
        state_s = ST_IDLE;
`endif
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Command latch, shift register, byte/word counters and load address.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cmd_r       <= 8'h00;
      shift_r     <= '0;
      byte_cnt_r  <= '0;
      word_cnt_r  <= '0;
      load_addr_r <= '0;
      from_run_r  <= 1'b0;
`ifdef DBG_BREAKPOINT_EN
      bp_addr_r   <= '0;
      bp_valid_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          byte_cnt_r <= '0;
          word_cnt_r <= '0;
          if (rx_hs_s) cmd_r <= i_rx_data;
        end
        ST_CMD: begin
          from_run_r <= (cmd_r == CMD_RUN);
`ifdef DBG_BREAKPOINT_EN
          if (cmd_r == CMD_BP_CLR) bp_valid_r <= 1'b0;
`endif
        end
        ST_LOAD, ST_BP_LOAD: begin
          if (rx_hs_s) begin
            shift_r    <= shift_next_s;
            byte_cnt_r <= byte_last_s ? '0 : byte_cnt_r + 16'd1;
`ifdef DBG_BREAKPOINT_EN
            if (state_r == ST_BP_LOAD && byte_last_s) begin
              bp_addr_r  <= shift_next_s;
              bp_valid_r <= 1'b1;
            end
`endif
          end
        end
        // The load address rolls over naturally at 2^NB_WORD.
        ST_WRITE: load_addr_r <= is_halt_s ? '0 : load_addr_r + NB_WORD'(32'd4);
        ST_DUMP_REG, ST_DUMP_MEM: begin
          if (tx_hs_s) begin
            if (byte_last_s) begin
              byte_cnt_r <= '0;
              word_cnt_r <= word_last_s ? '0 : word_cnt_r + 16'd1;
            end else begin
              byte_cnt_r <= byte_cnt_r + 16'd1;
            end
          end
        end
        ST_DUMP_LAT: begin
          if (tx_hs_s) byte_cnt_r <= lat_last_s ? '0 : byte_cnt_r + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode; transmit data follows the counters so it holds while stalled.
  always_comb begin
    o_rx_ready   = 1'b0;
    o_tx_valid   = 1'b0;
    o_tx_data    = 8'h00;
    o_dbg_addr   = '0;
    o_inst       = '0;
    o_w_mem      = 1'b0;
    o_enable     = 1'b0;
    o_reset_mips = 1'b0;
    o_busy       = (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE, ST_LOAD, ST_BP_LOAD: o_rx_ready = 1'b1;
      ST_WRITE: begin
        o_w_mem    = 1'b1;
        o_inst     = shift_r;
        o_dbg_addr = load_addr_r;
      end
      ST_RUN:  o_enable = !(i_halt || bp_hit_s);
      ST_STEP: o_enable = 1'b1;
      ST_DUMP_REG: begin
        o_tx_valid = 1'b1;
        o_dbg_addr = NB_WORD'(word_cnt_r);
        o_tx_data  = word_byte(i_reg_data, byte_cnt_r);
      end
      ST_DUMP_MEM: begin
        o_tx_valid = 1'b1;
        o_dbg_addr = NB_WORD'({word_cnt_r, 2'b00});
        o_tx_data  = word_byte(i_mem_data, byte_cnt_r);
      end
      ST_DUMP_LAT: begin
        o_tx_valid = 1'b1;
        o_tx_data  = latch_byte(i_latch, byte_cnt_r);
      end
      ST_RST: o_reset_mips = 1'b1;
      ST_ACK: begin
        o_tx_valid = 1'b1;
        o_tx_data  = BYTE_ACK;
      end
      ST_NAK: begin
        o_tx_valid = 1'b1;
        o_tx_data  = BYTE_NAK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbg_cmd_engine.sv
// Self-checking bench for dbg_cmd_engine: command table, load/run/reset sequences
// and randomized dumps compared against a byte-stream model built from plain arrays.
module tb_dbg_cmd_engine;

  localparam int NB_WORD    = 32;
  localparam int N_REGS     = 32;
  localparam int N_MEM      = 32;
  localparam int NB_LATCH   = 376;
  localparam int DUMP_BYTES = 4 * N_REGS + 4 * N_MEM + NB_LATCH / 8;
  localparam logic [31:0] HALT = 32'h0000003F;

  logic                i_clk = 1'b0;
  logic                i_reset_n;
  logic [7:0]          i_rx_data;
  logic                i_rx_valid;
  logic                o_rx_ready;
  logic [7:0]          o_tx_data;
  logic                o_tx_valid;
  logic                i_tx_ready;
  logic [NB_WORD-1:0]  i_reg_data;
  logic [NB_WORD-1:0]  i_mem_data;
  logic [NB_LATCH-1:0] i_latch;
  logic [NB_WORD-1:0]  i_pc;
  logic                i_halt;
  logic [NB_WORD-1:0]  o_dbg_addr;
  logic [NB_WORD-1:0]  o_inst;
  logic                o_w_mem;
  logic                o_enable;
  logic                o_reset_mips;
  logic                o_busy;

  always #5 i_clk = ~i_clk;

  dbg_cmd_engine #(
    .NB_WORD(NB_WORD), .N_REGS(N_REGS), .N_MEM_WORDS(N_MEM),
    .NB_LATCH(NB_LATCH), .HALT_WORD(HALT)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .i_reg_data(i_reg_data), .i_mem_data(i_mem_data), .i_latch(i_latch),
    .i_pc(i_pc), .i_halt(i_halt), .o_dbg_addr(o_dbg_addr), .o_inst(o_inst),
    .o_w_mem(o_w_mem), .o_enable(o_enable), .o_reset_mips(o_reset_mips), .o_busy(o_busy)
  );

  // CPU-side model: register file, data memory and latch bus.
  logic [31:0]         reg_file [N_REGS];
  logic [31:0]         mem_arr  [N_MEM];
  logic [NB_LATCH-1:0] latch_v;

  assign i_reg_data = reg_file[int'(o_dbg_addr % 32'(N_REGS))];
  assign i_mem_data = mem_arr[int'((o_dbg_addr >> 2) % 32'(N_MEM))];
  assign i_latch    = latch_v;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [63:0] wr_q[$];
  int          en_cnt, rst_cnt, cyc, last_tx_cyc, rst_cyc;
  logic        rx_hs, busy_smp, en_smp, prev_stall, pc_model_on;
  logic [7:0]  prev_data;
  logic [31:0] prev_addr;

  typedef struct {
    logic [7:0] cmd;
    logic       halt;
    int         n_tx;
    logic [7:0] first_tx;
    int         n_en;
    int         n_rst;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample 1 ns after the falling edge, let the rising edge pass, return at the next falling edge.
  task automatic tick();
    #1;
    cyc++;
    if (prev_stall) chk("tx_hold", {o_tx_valid, o_tx_data, o_dbg_addr}, {1'b1, prev_data, prev_addr});
    chk("strobe_excl", 64'(($countones({o_enable, o_w_mem, o_reset_mips}) > 1)), 64'd0);
    prev_stall = o_tx_valid && !i_tx_ready && i_reset_n;
    prev_data  = o_tx_data;
    prev_addr  = o_dbg_addr;
    if (o_tx_valid && i_tx_ready && i_reset_n) begin
      tx_q.push_back(o_tx_data);
      last_tx_cyc = cyc;
    end
    if (o_w_mem) wr_q.push_back({o_dbg_addr, o_inst});
    if (o_enable) en_cnt++;
    if (o_reset_mips) begin
      rst_cnt++;
      rst_cyc = cyc;
    end
    rx_hs    = i_rx_valid && o_rx_ready;
    busy_smp = o_busy;
    en_smp   = o_enable;
    @(negedge i_clk);
    if (pc_model_on && en_smp) i_pc = i_pc + 32'd4;
  endtask

  task automatic clear_mon();
    tx_q.delete();
    wr_q.delete();
    en_cnt = 0; rst_cnt = 0; last_tx_cyc = 0; rst_cyc = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!rx_hs && n < 50);
    i_rx_valid = 1'b0;
    chk("rx_accept", 64'(rx_hs), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic run_until_idle(input int budget, input bit rand_ready);
    int n;
    n = 0;
    do begin
      i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end while (busy_smp && n < budget);
    i_tx_ready = 1'b1;
    chk("idle_timeout", 64'(busy_smp), 64'd0);
  endtask

  task automatic randomize_cpu();
    for (int r = 0; r < N_REGS; r++) reg_file[r] = $urandom;
    for (int m = 0; m < N_MEM; m++) mem_arr[m] = $urandom;
    for (int k = 0; k < NB_LATCH; k++) latch_v[k] = 1'($urandom_range(0, 1));
  endtask

  // Expected dump: every register word, then every memory word, MSB first, then the latch bus from its top byte.
  task automatic build_exp();
    exp_q.delete();
    for (int r = 0; r < N_REGS; r++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'((reg_file[r] >> (8 * b)) & 32'hFF));
    for (int m = 0; m < N_MEM; m++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'((mem_arr[m] >> (8 * b)) & 32'hFF));
    for (int k = 0; k < NB_LATCH / 8; k++) exp_q.push_back(latch_v[NB_LATCH-1-8*k -: 8]);
  endtask

  task automatic compare_stream(input string name);
    int bad;
    bad = 0;
    chk({name, "_len"}, 64'(tx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++)
      if (tx_q[i] !== exp_q[i]) bad++;
    chk({name, "_bytes_wrong"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words[$];
    int          n;

    i_reset_n = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0; i_tx_ready = 1'b1;
    i_pc = 32'd0; i_halt = 1'b0; pc_model_on = 1'b0; prev_stall = 1'b0; cyc = 0;
    randomize_cpu();
    build_exp();
    clear_mon();

    vecs[0] = '{cmd: 8'h7F, halt: 1'b0, n_tx: 1, first_tx: 8'hEE, n_en: 0, n_rst: 0};
    vecs[1] = '{cmd: 8'h0C, halt: 1'b0, n_tx: 0, first_tx: 8'h00, n_en: 0, n_rst: 1};
    vecs[2] = '{cmd: 8'h05, halt: 1'b0, n_tx: DUMP_BYTES, first_tx: reg_file[0][31:24], n_en: 1, n_rst: 0};
    vecs[3] = '{cmd: 8'h05, halt: 1'b1, n_tx: DUMP_BYTES, first_tx: reg_file[0][31:24], n_en: 1, n_rst: 0};
    vecs[4] = '{cmd: 8'h00, halt: 1'b0, n_tx: 1, first_tx: 8'hEE, n_en: 0, n_rst: 0};
`ifdef DBG_BREAKPOINT_EN
    vecs[5] = '{cmd: 8'hFF, halt: 1'b0, n_tx: 1, first_tx: 8'hEE, n_en: 0, n_rst: 0};
    vecs[6] = '{cmd: 8'h11, halt: 1'b0, n_tx: 1, first_tx: 8'hAC, n_en: 0, n_rst: 0};
`else
    vecs[5] = '{cmd: 8'h10, halt: 1'b0, n_tx: 1, first_tx: 8'hEE, n_en: 0, n_rst: 0};
    vecs[6] = '{cmd: 8'h11, halt: 1'b0, n_tx: 1, first_tx: 8'hEE, n_en: 0, n_rst: 0};
`endif

    @(negedge i_clk);
    repeat (3) tick();
    chk("reset_strobes", 64'({o_tx_valid, o_w_mem, o_enable, o_reset_mips, o_busy}), 64'd0);
    chk("reset_inst", 64'(o_inst), 64'd0);
    chk("reset_addr", 64'(o_dbg_addr), 64'd0);
    i_reset_n = 1'b1;
    chk("reset_rx_ready", 64'(o_rx_ready), 64'd1);

    // Command table: one byte in, observe everything until the engine is idle again.
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      i_halt = vecs[v].halt;
      send_byte(vecs[v].cmd);
      run_until_idle(2000, 1'b0);
      i_halt = 1'b0;
      chk($sformatf("vec%0d_ntx", v), 64'(tx_q.size()), 64'(vecs[v].n_tx));
      chk($sformatf("vec%0d_first", v), 64'((tx_q.size() > 0) ? tx_q[0] : 8'h00), 64'(vecs[v].first_tx));
      chk($sformatf("vec%0d_enable", v), 64'(en_cnt), 64'(vecs[v].n_en));
      chk($sformatf("vec%0d_rst", v), 64'(rst_cnt), 64'(vecs[v].n_rst));
      chk($sformatf("vec%0d_wmem", v), 64'(wr_q.size()), 64'd0);
      if (vecs[v].n_tx == DUMP_BYTES) compare_stream($sformatf("vec%0d_dump", v));
    end

    // Two-word program load.
    clear_mon();
    send_byte(8'h04);
    send_word(32'h20010005);
    send_word(HALT);
    run_until_idle(100, 1'b0);
    chk("load_count", 64'(wr_q.size()), 64'd2);
    chk("load_w0", (wr_q.size() > 0) ? wr_q[0] : 64'd0, {32'd0, 32'h20010005});
    chk("load_w1", (wr_q.size() > 1) ? wr_q[1] : 64'd0, {32'd4, HALT});

    // Random-length programs; the address restarts at 0 after each halt word.
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      words.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        words.push_back($urandom);
        if (words[i] == HALT) words[i] = words[i] ^ 32'd1;
      end
      words.push_back(HALT);
      send_byte(8'h04);
      foreach (words[i]) send_word(words[i]);
      run_until_idle(100, 1'b0);
      chk($sformatf("rload%0d_count", t), 64'(wr_q.size()), 64'(words.size()));
      for (int i = 0; i < words.size() && i < wr_q.size(); i++)
        chk($sformatf("rload%0d_w%0d", t, i), wr_q[i], {32'(4 * i), words[i]});
    end

    // Reset in the middle of the second word: no further write, clean idle afterwards.
    clear_mon();
    send_byte(8'h04);
    send_word(32'hCAFE0001);
    send_byte(8'h12);
    send_byte(8'h34);
    i_reset_n = 1'b0;
    repeat (2) tick();
    chk("midrst_strobes", 64'({o_tx_valid, o_w_mem, o_enable, o_reset_mips, o_busy}), 64'd0);
    chk("midrst_inst", 64'(o_inst), 64'd0);
    chk("midrst_addr", 64'(o_dbg_addr), 64'd0);
    i_reset_n = 1'b1;
    chk("midrst_rx_ready", 64'(o_rx_ready), 64'd1);
    chk("midrst_writes", 64'(wr_q.size()), 64'd1);
    chk("midrst_w0", (wr_q.size() > 0) ? wr_q[0] : 64'd0, {32'd0, 32'hCAFE0001});
    clear_mon();
    send_byte(8'h04);
    send_word(HALT);
    run_until_idle(100, 1'b0);
    chk("midrst_addr_cleared", (wr_q.size() > 0) ? wr_q[0] : 64'd0, {32'd0, HALT});

    // Run until halt after 10 enabled cycles, with a randomly stalling transmitter.
    randomize_cpu();
    build_exp();
    clear_mon();
    send_byte(8'h03);
    n = 0;
    while (en_cnt < 10 && n < 100) begin
      i_tx_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    chk("run_halt_gates_enable", 64'(en_cnt), 64'd10);
    run_until_idle(5000, 1'b1);
    compare_stream("run_dump");
    chk("run_rst_pulses", 64'(rst_cnt), 64'd1);
    chk("run_rst_after_dump", 64'(rst_cyc > last_tx_cyc), 64'd1);
    chk("run_enable_total", 64'(en_cnt), 64'd10);

`ifdef DBG_BREAKPOINT_EN
    // Breakpoint at PC 8 stops the run with the CPU advancing 4 per enabled cycle.
    clear_mon();
    send_byte(8'h10);
    send_word(32'h00000008);
    run_until_idle(100, 1'b0);
    chk("bp_ack_len", 64'(tx_q.size()), 64'd1);
    chk("bp_ack", 64'((tx_q.size() > 0) ? tx_q[0] : 8'h00), 64'hAC);
    clear_mon();
    build_exp();
    i_pc = 32'd0;
    pc_model_on = 1'b1;
    send_byte(8'h03);
    run_until_idle(5000, 1'b1);
    pc_model_on = 1'b0;
    chk("bp_enable_cycles", 64'(en_cnt), 64'd2);
    chk("bp_pc", 64'(i_pc), 64'd8);
    compare_stream("bp_dump");
    chk("bp_rst_pulses", 64'(rst_cnt), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_engine.md
DBG_CMD_ENGINE -- requirements
Module: dbg_cmd_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NB_WORD, 32, datapath word width; multiple of 8.
- N_REGS, 32, register-file words dumped.
- N_MEM_WORDS, 32, data-memory words dumped.
- NB_LATCH, 376, pipeline-latch bus width; multiple of 8.
- HALT_WORD, 32'h0000003F, end-of-program marker.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1, sole clock; all logic on its rising edge.
- i_reset_n, in, 1, synchronous active-low reset.
- i_rx_data, in, 8, received byte.
- i_rx_valid, in, 1, received byte available.
- o_rx_ready, out, 1, byte consumed when i_rx_valid and o_rx_ready are both high.
- o_tx_data, out, 8, byte to transmit.
- o_tx_valid, out, 1, o_tx_data valid.
- i_tx_ready, in, 1, byte accepted when o_tx_valid and i_tx_ready are both high.
- i_reg_data, in, NB_WORD, register read data for o_dbg_addr, combinational.
- i_mem_data, in, NB_WORD, memory read data for o_dbg_addr, combinational.
- i_latch, in, NB_LATCH, concatenated pipeline latches.
- i_pc, in, NB_WORD, current CPU PC.
- i_halt, in, 1, CPU executed halt.
- o_dbg_addr, out, NB_WORD, register index or byte address.
- o_inst, out, NB_WORD, word to write into instruction memory.
- o_w_mem, out, 1, instruction-memory write strobe.
- o_enable, out, 1, CPU clock enable.
- o_reset_mips, out, 1, CPU reset pulse.
- o_busy, out, 1, high in every state except IDLE.

Function
REQ-003 The FSM SHALL have these states: IDLE, CMD, LOAD, WRITE, RUN, STEP, DUMP_REG, DUMP_MEM, DUMP_LAT, FINISH, RST, ACK, NAK, BP_LOAD.
REQ-004 The FSM SHALL assert o_rx_ready only in IDLE, LOAD and BP_LOAD; in IDLE, a handshaked byte SHALL be latched and the FSM SHALL enter CMD.
REQ-005 CMD SHALL decode the latched byte in one cycle:
- 0x04 goes to LOAD.
- 0x03 goes to RUN.
- 0x05 goes to STEP.
- 0x0C goes to RST.
- Any other value goes to NAK.
REQ-006 LOAD SHALL shift bytes in MSB first; after NB_WORD/8 handshakes, it SHALL go to WRITE.
REQ-007 WRITE SHALL:
- Assert o_w_mem for exactly 1 cycle, with o_inst equal to the assembled word and o_dbg_addr equal to the load address.
- If o_inst equals HALT_WORD, clear the load address and go to IDLE.
- Otherwise, add 4 to the load address and return to LOAD.
REQ-008 The load address SHALL wrap modulo 2^NB_WORD without error.
REQ-009 RUN SHALL hold o_enable high every cycle until i_halt is high.
- On that cycle o_enable SHALL be 0 (combinational gating).
- The FSM SHALL then go to DUMP_REG.
REQ-010 STEP SHALL assert o_enable for exactly 1 cycle, then go to DUMP_REG regardless of i_halt.
REQ-011 DUMP_REG SHALL send N_REGS words, index 0 first, each MSB byte first, with o_dbg_addr equal to the index.
REQ-012 DUMP_MEM SHALL send N_MEM_WORDS words from byte addresses 0, 4, 8, ..., each MSB byte first.
REQ-013 DUMP_LAT SHALL send NB_LATCH/8 bytes, i_latch[NB_LATCH-1 -: 8] first.
REQ-014 A dump SHALL total 4*N_REGS + 4*N_MEM_WORDS + NB_LATCH/8 bytes (with NB_WORD = 32) and then enter FINISH.
REQ-015 The transmit handshake SHALL follow these rules:
- o_tx_data and o_dbg_addr stay stable while o_tx_valid is high and i_tx_ready is low.
- The byte counter advances only on a handshake.
- No byte is dropped or duplicated under arbitrary i_tx_ready stalls.
REQ-016 FINISH SHALL route to RST if the dump was entered from RUN, and to IDLE if entered from STEP.
REQ-017 RST SHALL assert o_reset_mips for exactly 1 cycle and then go to IDLE.
REQ-018 NAK SHALL send 0xEE once and then go to IDLE; ACK SHALL send 0xAC once and then go to IDLE.
REQ-019 o_enable, o_w_mem and o_reset_mips SHALL be mutually exclusive in every cycle.

Reset
REQ-020 While i_reset_n is low at a clock edge, the block SHALL:
- Force state IDLE and clear all counters, the load address and the data registers.
- Set o_tx_valid, o_w_mem, o_enable, o_reset_mips, o_busy, o_inst and o_dbg_addr to 0.
REQ-021 Reset mid-transfer SHALL abort with no partial instruction write, and o_rx_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-022 With macro DBG_BREAKPOINT_EN defined:
- CMD SHALL decode 0x10 to BP_LOAD, which takes NB_WORD/8 bytes MSB first into bp_addr, sets bp_valid, then goes to ACK.
- CMD SHALL decode 0x11 to clear bp_valid, then go to ACK.
- In RUN, if bp_valid is set and i_pc equals bp_addr, o_enable SHALL be 0 that cycle and the FSM SHALL go to DUMP_REG.
- bp_valid SHALL reset to 0.
REQ-023 Without DBG_BREAKPOINT_EN:
- No breakpoint registers exist.
- Bytes 0x10 and 0x11 take the NAK path.

Verification
REQ-024 Send 0x04, then 0x20010005 and 0x0000003F -> o_w_mem pulses twice, at address 0 with 0x20010005 and at address 4 with 0x0000003F, and the FSM returns to IDLE.
REQ-025 Send 0x05 with i_tx_ready high -> o_enable high for exactly 1 cycle, then 303 bytes (defaults), the first byte being the register-0 MSB, and o_reset_mips stays 0.
REQ-026 Send 0x03, raise i_halt after 10 cycles, toggle i_tx_ready at random -> 303 bytes matching the model in order, then a 1-cycle o_reset_mips pulse.
REQ-027 Send 0x7F -> single byte 0xEE and no CPU strobes; send 0x0C -> a 1-cycle o_reset_mips pulse only.
REQ-028 With DBG_BREAKPOINT_EN, send 0x10 and 0x00000008 -> byte 0xAC; then send 0x03 with i_pc stepping 0, 4, 8 -> o_enable drops when i_pc is 8 and a dump follows.
REQ-029 Drive i_reset_n low during the second word of a LOAD -> no further o_w_mem pulse, all outputs 0, and the FSM is in IDLE after release.
